commit_trace_buffer: RTL and testbench

Parametrised, synthesizable on-chip trace capture unit for the single-cycle RISC-V core. It taps the per-instruction commit signals (PC, instruction, ALU result, write data, RegWrite, Branch) into a circular buffer. Capture freezes on a programmable trigger plus a post-trigger count. The frozen window then drains oldest-first over a valid/ready stream, so the core can be debugged in silicon or in long simulations without printing every cycle.

---
 rtl/commit_trace_buffer_if.sv | 46 ++++
 rtl/commit_trace_buffer.sv | 125 ++++++++++++
 tb/tb_commit_trace_buffer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/commit_trace_buffer_if.sv
// Bundle between the core commit tap / debug consumer and the trace buffer.
// slave is the buffer's view; master is the driver/consumer side.
interface commit_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
);
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_alu;
  logic [XLEN-1:0] in_wdata;
  logic            in_regwrite;
  logic            in_branch;
  logic            arm;
  logic            abort;
  logic [1:0]      trig_mode;
  logic [XLEN-1:0] trig_pc;
  logic            ext_trig;
  logic [AW:0]     post_count;
  logic            out_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_alu;
  logic [XLEN-1:0] out_wdata;
  logic            out_regwrite;
  logic            out_branch;
  logic            out_last;
  logic [1:0]      state;
  logic            triggered;
  logic [AW:0]     fill_count;

  modport slave (
    input  in_valid, in_pc, in_instr, in_alu, in_wdata, in_regwrite, in_branch,
           arm, abort, trig_mode, trig_pc, ext_trig, post_count, out_ready,
    output out_valid, out_pc, out_instr, out_alu, out_wdata, out_regwrite,
           out_branch, out_last, state, triggered, fill_count
  );
  modport master (
    output in_valid, in_pc, in_instr, in_alu, in_wdata, in_regwrite, in_branch,
           arm, abort, trig_mode, trig_pc, ext_trig, post_count, out_ready,
    input  out_valid, out_pc, out_instr, out_alu, out_wdata, out_regwrite,
           out_branch, out_last, state, triggered, fill_count
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Circular commit-trace capture: records samples until trigger + post count,
// then drains the frozen window oldest-first over a valid/ready stream.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  commit_trace_buffer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_POST = 2'd2, S_DRAIN = 2'd3} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic            regwrite;
    logic            branch;
  } entry_t;

  localparam logic [AW:0]   FILL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   FILL_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};

  entry_t          mem [DEPTH];
  state_e          st, st_nxt;
  logic [1:0]      mode_q;
  logic [XLEN-1:0] tpc_q;
  logic [AW:0]     post_q, post_left, fill;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            trig_q;
  logic            wr_en, hit, xfer, ovalid;
  entry_t          rd_e;

  always_comb begin
    unique case (mode_q)
      2'd0:    hit = 1'b1;
      2'd1:    hit = (bus.in_pc == tpc_q);
      2'd2:    hit = bus.in_branch;
      default: hit = bus.ext_trig;
    endcase
  end

  assign wr_en  = !bus.abort && bus.in_valid && (st == S_PRE || st == S_POST);
  assign ovalid = (st == S_DRAIN) && (fill != '0);
  assign xfer   = !bus.abort && ovalid && bus.out_ready;
  // Oldest entry sits fill_count slots behind the write pointer; a full
  // buffer wraps to wr_ptr itself.
  assign rd_ptr = wr_ptr - fill[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (bus.abort) st_nxt = S_IDLE;
    else begin
      unique case (st)
        S_IDLE:  if (bus.arm) st_nxt = S_PRE;
        S_PRE:   if (wr_en && hit) st_nxt = (post_q == '0) ? S_DRAIN : S_POST;
        S_POST:  if (wr_en && post_left == FILL_ONE) st_nxt = S_DRAIN;
        default: if (fill == '0 || (xfer && fill == FILL_ONE)) st_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= '0;
      tpc_q     <= '0;
      post_q    <= '0;
      post_left <= '0;
      fill      <= '0;
      wr_ptr    <= '0;
      trig_q    <= 1'b0;
    end else if (bus.abort) begin
      fill <= '0;
    end else begin
      if (st == S_IDLE && bus.arm) begin
        mode_q <= bus.trig_mode;
        tpc_q  <= bus.trig_pc;
        post_q <= bus.post_count;
        wr_ptr <= '0;
        fill   <= '0;
        trig_q <= 1'b0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (fill != FILL_FULL) fill <= fill + FILL_ONE;
      end
      if (st == S_PRE && wr_en && hit) begin
        trig_q    <= 1'b1;
        post_left <= post_q;
      end
      if (st == S_POST && wr_en) post_left <= post_left - FILL_ONE;
      if (xfer) fill <= fill - FILL_ONE;
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr, alu: bus.in_alu,
                       wdata: bus.in_wdata, regwrite: bus.in_regwrite,
                       branch: bus.in_branch};
  end

  assign rd_e = ovalid ? mem[rd_ptr] : '0;

  assign bus.out_valid    = ovalid;
  assign bus.out_pc       = rd_e.pc;
  assign bus.out_instr    = rd_e.instr;
  assign bus.out_alu      = rd_e.alu;
  assign bus.out_wdata    = rd_e.wdata;
  assign bus.out_regwrite = rd_e.regwrite;
  assign bus.out_branch   = rd_e.branch;
  assign bus.out_last     = ovalid && (fill == FILL_ONE);
  assign bus.state        = st;
  assign bus.triggered    = trig_q;
  assign bus.fill_count   = fill;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a queue-based reference model
// checked every cycle, plus literal drain-order expectations per scenario.
module tb_commit_trace_buffer;
  localparam int XLEN = 32, DEPTH = 8, AW = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  commit_trace_buffer_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  commit_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { logic [31:0] pc, instr, alu, wdata; logic rw, br; } smp_t;

  smp_t        mq[$];
  int          mst = 0, mmode = 0, mpost = 0, mleft = 0;
  logic [31:0] mtpc = '0;
  bit          mtrig = 0;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] got_pc[$];
  logic [31:0] got_last = '0;
  bit          saw_valid = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic smp_t mk(logic [31:0] pc, logic br);
    smp_t s;
    s.pc = pc; s.instr = pc ^ 32'h0000_0013; s.alu = pc + 32'd1;
    s.wdata = pc * 32'd3; s.rw = pc[2]; s.br = br;
    return s;
  endfunction

  // Reference: the capture is just a bounded queue of stored samples.
  task automatic model_step();
    smp_t s;
    bit   h;
    if (bus.abort) begin
      mst = 0; mq.delete();
      return;
    end
    s = mk(bus.in_pc, bus.in_branch);
    s.instr = bus.in_instr; s.alu = bus.in_alu; s.wdata = bus.in_wdata; s.rw = bus.in_regwrite;
    h = (mmode == 0) || (mmode == 1 && bus.in_pc == mtpc) ||
        (mmode == 2 && bus.in_branch) || (mmode == 3 && bus.ext_trig);
    case (mst)
      0: if (bus.arm) begin
           mmode = int'(bus.trig_mode); mtpc = bus.trig_pc; mpost = int'(bus.post_count);
           mq.delete(); mtrig = 0; mst = 1;
         end
      1, 2: if (bus.in_valid) begin
           mq.push_back(s);
           if (mq.size() > DEPTH) void'(mq.pop_front());
           if (mst == 1) begin
             if (h) begin
               mtrig = 1;
               if (mpost == 0) mst = 3; else begin mleft = mpost; mst = 2; end
             end
           end else begin
             mleft--;
             if (mleft == 0) mst = 3;
           end
         end
      default: if (mq.size() > 0 && bus.out_ready) begin
           void'(mq.pop_front());
           if (mq.size() == 0) mst = 0;
         end
    endcase
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mq.delete(); mst = 0; mtrig = 0; mleft = 0;
    end
    check("state", bus.state, mst);
    check("triggered", bus.triggered, mtrig);
    check("fill_count", bus.fill_count, mq.size());
    check("out_valid", bus.out_valid, (mst == 3 && mq.size() > 0));
    if (mst == 3 && mq.size() > 0) begin
      check("out_pc", bus.out_pc, mq[0].pc);
      check("out_instr", bus.out_instr, mq[0].instr);
      check("out_alu", bus.out_alu, mq[0].alu);
      check("out_wdata", bus.out_wdata, mq[0].wdata);
      check("out_flags", {bus.out_regwrite, bus.out_branch}, {mq[0].rw, mq[0].br});
      check("out_last", bus.out_last, mq.size() == 1);
    end else begin
      check("out_pc_idle", bus.out_pc, 0);
      check("out_last_idle", bus.out_last, 0);
    end
    if (bus.out_valid) saw_valid = 1;
    if (bus.out_valid && bus.out_ready) begin
      got_pc.push_back(bus.out_pc);
      if (bus.out_last) got_last = bus.out_pc;
    end
    if (rst_n) model_step();
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(logic [31:0] pc, logic br);
    smp_t s = mk(pc, br);
    bus.in_valid = 1; bus.in_pc = s.pc; bus.in_instr = s.instr; bus.in_alu = s.alu;
    bus.in_wdata = s.wdata; bus.in_regwrite = s.rw; bus.in_branch = s.br;
    step();
    bus.in_valid = 0;
  endtask

  task automatic gap();
    bus.in_valid = 0; bus.in_pc = 32'hDEAD_BEE0; bus.in_branch = 1; bus.ext_trig = 1;
    step();
    bus.in_branch = 0; bus.ext_trig = 0;
  endtask

  task automatic arm_cap(int mode, logic [31:0] tpc, int post);
    bus.trig_mode = 2'(mode); bus.trig_pc = tpc; bus.post_count = (AW+1)'(post);
    bus.arm = 1; step(); bus.arm = 0;
    got_pc.delete(); got_last = '0;
  endtask

  // Drain until IDLE; pattern 1 gives out_ready 1,0,0,1 repeating.
  task automatic drain(int pat);
    logic [31:0] prev_pc = '0;
    bit stalled = 0;
    int k = 0;
    while (bus.state != 2'd0 && k < 60) begin
      if (stalled) check("stall_hold", bus.out_pc, prev_pc);
      bus.out_ready = (pat == 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
      stalled = bus.out_valid && !bus.out_ready;
      prev_pc = bus.out_pc;
      step(); k++;
    end
    bus.out_ready = 0;
    check("drain_timeout", bus.state, 0);
  endtask

  initial begin
    logic [31:0] e1[4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] e3[5] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
    logic [31:0] e5[4] = '{32'h0, 32'h4, 32'h8, 32'h100};
    logic [31:0] e6[3] = '{32'h300, 32'h304, 32'h308};
    bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0; bus.in_alu = '0; bus.in_wdata = '0;
    bus.in_regwrite = 0; bus.in_branch = 0; bus.arm = 0; bus.abort = 0; bus.trig_mode = '0;
    bus.trig_pc = '0; bus.ext_trig = 0; bus.post_count = '0; bus.out_ready = 0;
    step(); step();
    check("rst_state", bus.state, 0);
    check("rst_fill", bus.fill_count, 0);
    check("rst_valid", bus.out_valid, 0);
    rst_n = 1; step();

    // Immediate trigger, post 3.
    arm_cap(0, 0, 3);
    for (int i = 0; i < 5; i++) begin
      send(32'(i * 4), 0);
      if (i == 3) check("t1_drain_after_0c", bus.state, 3);
    end
    check("t1_fill", bus.fill_count, 4);
    drain(0);
    check("t1_count", got_pc.size(), 4);
    foreach (e1[i]) if (i < got_pc.size()) check("t1_order", got_pc[i], e1[i]);
    check("t1_last", got_last, 32'hC);
    check("t1_idle_fill", bus.fill_count, 0);

    // PC match with wraparound.
    arm_cap(1, 32'h20, 2);
    for (int i = 0; i <= 16; i++) send(32'(i * 4), 0);
    check("t2_fill", bus.fill_count, 8);
    drain(0);
    check("t2_count", got_pc.size(), 8);
    for (int i = 0; i < 8; i++) if (i < got_pc.size()) check("t2_order", got_pc[i], 32'(32'hC + i * 4));

    // Branch trigger with input gaps and a stalling consumer.
    arm_cap(2, 0, 2);
    send(32'h40, 0); gap(); send(32'h44, 0); send(32'h48, 1); gap(); gap();
    send(32'h4C, 0); gap(); send(32'h50, 1);
    check("t3_state", bus.state, 3);
    check("t3_fill", bus.fill_count, 5);
    drain(1);
    check("t3_count", got_pc.size(), 5);
    foreach (e3[i]) if (i < got_pc.size()) check("t3_order", got_pc[i], e3[i]);

    // Abort in POST, then abort+arm in IDLE.
    saw_valid = 0;
    arm_cap(2, 0, 10);
    send(32'h0, 0); send(32'h4, 0); send(32'h8, 1); send(32'hC, 0); send(32'h10, 0);
    check("t4_in_post", bus.state, 2);
    bus.abort = 1; step(); bus.abort = 0;
    check("t4_abort_state", bus.state, 0);
    check("t4_abort_fill", bus.fill_count, 0);
    step(); step();
    bus.abort = 1; bus.arm = 1; step(); bus.abort = 0; bus.arm = 0;
    check("t4_abort_arm", bus.state, 0);
    check("t4_no_valid", saw_valid, 0);

    // Re-arm during PRE is ignored.
    arm_cap(1, 32'h100, 0);
    send(32'h0, 0);
    bus.arm = 1; bus.trig_pc = 32'h8; send(32'h4, 0); bus.arm = 0;
    send(32'h8, 0);
    check("t5_still_pre", bus.state, 1);
    send(32'h100, 0);
    check("t5_drain", bus.state, 3);
    drain(0);
    check("t5_count", got_pc.size(), 4);
    foreach (e5[i]) if (i < got_pc.size()) check("t5_order", got_pc[i], e5[i]);

    // Reset mid-drain, then a fresh external-trigger capture.
    arm_cap(0, 0, 5);
    for (int i = 0; i < 6; i++) send(32'(32'h200 + i * 4), 0);
    bus.out_ready = 1; step(); step(); bus.out_ready = 0;
    check("t6_fill_mid", bus.fill_count, 4);
    rst_n = 0; #1;
    check("t6_rst_state", bus.state, 0);
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_fill", bus.fill_count, 0);
    check("t6_rst_trig", bus.triggered, 0);
    check("t6_rst_pc", bus.out_pc, 0);
    step(); rst_n = 1; step();
    check("t6_xfers", got_pc.size(), 2);
    if (got_pc.size() == 2) check("t6_second", got_pc[1], 32'h204);
    arm_cap(3, 0, 1);
    send(32'h300, 0);
    bus.ext_trig = 1; send(32'h304, 0); bus.ext_trig = 0;
    send(32'h308, 0);
    check("t6_drain", bus.state, 3);
    drain(0);
    check("t6_count", got_pc.size(), 3);
    foreach (e6[i]) if (i < got_pc.size()) check("t6_order", got_pc[i], e6[i]);
    check("t6_trig_kept", bus.triggered, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
